// File: rtl/phy_pkg.sv
// Shared definitions for the MII receive framer: FSM encoding, nibble codes and CRC-32 constants.
package phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } rx_state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d4.sv
// Reflected CRC-32 accumulator taking one nibble per cycle, LSB first.
module eth_crc32_d4
    import phy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [3:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 4; i++) begin
            if (crc_next[0] ^ data[i]) begin
                crc_next = {1'b0, crc_next[31:1]} ^ POLY_REFL;
            end else begin
                crc_next = {1'b0, crc_next[31:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= '1;
        end else if (clear) begin
            crc_reg <= '1;
        end else if (enable) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: preamble/SFD hunt, nibble-to-word packing into the packet buffer, frame status.
// Optional FCS checking is compiled in with RX_FCS_CHECK_EN.
module mii_rx_framer
    import phy_pkg::*;
#(
    parameter int                ADDR_W     = 15,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(58),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(32767),
    parameter logic [3:0]        MIN_PRE    = 4'd6
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rx_enable,
    input  logic [3:0]        recieve,
    input  logic              recieve_data_valid,
    input  logic              recieve_ERR,
    output logic [15:0]       toMemory,
    output logic [ADDR_W-1:0] writeLocation,
    output logic              write,
    output logic              frame_done,
    output logic              frame_err,
    output logic [10:0]       frame_bytes,
    output logic              busy
);

    rx_state_t         state_reg, state_next;
    logic [3:0]        pre_cnt_reg, pre_cnt_next;
    logic [1:0]        nib_idx_reg, nib_idx_next;
    logic [15:0]       word_reg, word_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              write_reg, write_next;
    logic              full_reg, full_next;
    logic              ovf_reg, ovf_next;
    logic              err_reg, err_next;
    logic [10:0]       byte_cnt_reg, byte_cnt_next;
    logic [10:0]       bytes_out_reg, bytes_out_next;
    logic              ferr_reg, ferr_next;
    logic              done_reg, done_next;
    logic              busy_reg, busy_next;
    logic              wr_req;
    logic              full_now;
    logic              fcs_bad;

    // The write at END_ADDR still lands; anything requested after it is dropped.
    assign full_now = full_reg | (write_reg && (addr_reg == END_ADDR));

`ifdef RX_FCS_CHECK_EN
    logic [31:0] crc;

    eth_crc32_d4 u_crc (
        .clk    (CLK),
        .rst_n  (reset),
        .clear  (state_reg != ST_DATA),
        .enable ((state_reg == ST_DATA) && recieve_data_valid),
        .data   (recieve),
        .crc    (crc)
    );

    assign fcs_bad = (reflect32(crc) != CRC_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        nib_idx_next   = nib_idx_reg;
        word_next      = word_reg;
        addr_next      = addr_reg;
        full_next      = full_reg;
        ovf_next       = ovf_reg;
        err_next       = err_reg;
        byte_cnt_next  = byte_cnt_reg;
        bytes_out_next = bytes_out_reg;
        ferr_next      = ferr_reg;
        busy_next      = busy_reg;
        write_next     = 1'b0;
        done_next      = 1'b0;
        wr_req         = 1'b0;

        if (write_reg) begin
            if (addr_reg == END_ADDR) begin
                full_next = 1'b1;
            end else begin
                addr_next = addr_reg + ADDR_W'(1);
            end
        end

        if (busy_reg && recieve_ERR) begin
            err_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (recieve_data_valid && (recieve == PREAMBLE_NIB) && rx_enable) begin
                    state_next   = ST_PRE;
                    pre_cnt_next = 4'd1;
                end
            end
            ST_PRE: begin
                if (recieve_data_valid && (recieve == PREAMBLE_NIB)) begin
                    if (pre_cnt_reg != 4'hF) begin
                        pre_cnt_next = pre_cnt_reg + 4'd1;
                    end
                end else if (recieve_data_valid && (recieve == SFD_NIB) && (pre_cnt_reg >= MIN_PRE)) begin
                    state_next    = ST_DATA;
                    busy_next     = 1'b1;
                    nib_idx_next  = 2'd0;
                    word_next     = 16'h0000;
                    byte_cnt_next = 11'd0;
                    err_next      = 1'b0;
                    ovf_next      = 1'b0;
                    full_next     = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (recieve_data_valid) begin
                    // Starting a new word clears its low nibbles, so a short tail is already zero-padded.
                    case (nib_idx_reg)
                        2'd0:    word_next = {recieve, 12'h000};
                        2'd1:    word_next[11:8] = recieve;
                        2'd2:    word_next[7:4]  = recieve;
                        default: word_next[3:0]  = recieve;
                    endcase
                    nib_idx_next = nib_idx_reg + 2'd1;
                    if (nib_idx_reg == 2'd3) begin
                        wr_req = 1'b1;
                    end
                    if (nib_idx_reg[0] && (byte_cnt_reg != 11'h7FF)) begin
                        byte_cnt_next = byte_cnt_reg + 11'd1;
                    end
                end else begin
                    state_next = ST_DONE;
                    if (nib_idx_reg != 2'd0) begin
                        wr_req = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = ST_IDLE;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                addr_next      = START_ADDR;
                bytes_out_next = byte_cnt_reg;
                ferr_next      = err_reg | ovf_reg | fcs_bad;
            end
        endcase

        if (wr_req) begin
            if (full_now) begin
                ovf_next = 1'b1;
            end else begin
                write_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pre_cnt_reg   <= 4'd0;
            nib_idx_reg   <= 2'd0;
            word_reg      <= 16'h0000;
            addr_reg      <= START_ADDR;
            write_reg     <= 1'b0;
            full_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
            byte_cnt_reg  <= 11'd0;
            bytes_out_reg <= 11'd0;
            ferr_reg      <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            pre_cnt_reg   <= pre_cnt_next;
            nib_idx_reg   <= nib_idx_next;
            word_reg      <= word_next;
            addr_reg      <= addr_next;
            write_reg     <= write_next;
            full_reg      <= full_next;
            ovf_reg       <= ovf_next;
            err_reg       <= err_next;
            byte_cnt_reg  <= byte_cnt_next;
            bytes_out_reg <= bytes_out_next;
            ferr_reg      <= ferr_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
        end
    end

    assign toMemory      = word_reg;
    assign writeLocation = addr_reg;
    assign write         = write_reg;
    assign frame_done    = done_reg;
    assign frame_err     = ferr_reg;
    assign frame_bytes   = bytes_out_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Scoreboard bench for mii_rx_framer: one default instance and one with a small END_ADDR for overflow.
module tb_mii_rx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_enable;
    logic [3:0]  rxd;
    logic        rx_dv;
    logic        rx_er;

    logic [15:0] mem0, mem1;
    logic [14:0] loc0, loc1;
    logic        write0, write1, done0, done1, ferr0, ferr1, busy0, busy1;
    logic [10:0] bytes0, bytes1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [30:0] exp_wr0[$], exp_wr1[$];
    logic [11:0] exp_done0[$], exp_done1[$];
    logic [3:0]  fq[$];
    logic [30:0] ew0, ew1;
    logic [11:0] ed0, ed1;

    always #5 clk = ~clk;

    mii_rx_framer dut (
        .CLK(clk), .reset(rst_n), .rx_enable(rx_enable), .recieve(rxd),
        .recieve_data_valid(rx_dv), .recieve_ERR(rx_er),
        .toMemory(mem0), .writeLocation(loc0), .write(write0), .frame_done(done0),
        .frame_err(ferr0), .frame_bytes(bytes0), .busy(busy0)
    );

    mii_rx_framer #(.END_ADDR(15'd60)) dut_ovf (
        .CLK(clk), .reset(rst_n), .rx_enable(rx_enable), .recieve(rxd),
        .recieve_data_valid(rx_dv), .recieve_ERR(rx_er),
        .toMemory(mem1), .writeLocation(loc1), .write(write1), .frame_done(done1),
        .frame_err(ferr1), .frame_bytes(bytes1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (write0) begin
                if (exp_wr0.size() == 0) begin
                    check_eq("wr0_unexpected", 32'(write0), 32'd0);
                end else begin
                    ew0 = exp_wr0.pop_front();
                    check_eq("wr0_addr", 32'(loc0), 32'(ew0[30:16]));
                    check_eq("wr0_data", 32'(mem0), 32'(ew0[15:0]));
                    $display("dut  write %04h @ %0d", mem0, loc0);
                end
            end
            if (done0) begin
                if (exp_done0.size() == 0) begin
                    check_eq("done0_unexpected", 32'(done0), 32'd0);
                end else begin
                    ed0 = exp_done0.pop_front();
                    check_eq("done0_err", 32'(ferr0), 32'(ed0[11]));
                    check_eq("done0_bytes", 32'(bytes0), 32'(ed0[10:0]));
                    $display("dut  frame_done err=%0d bytes=%0d", ferr0, bytes0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (write1) begin
                if (exp_wr1.size() == 0) begin
                    check_eq("wr1_unexpected", 32'(write1), 32'd0);
                end else begin
                    ew1 = exp_wr1.pop_front();
                    check_eq("wr1_addr", 32'(loc1), 32'(ew1[30:16]));
                    check_eq("wr1_data", 32'(mem1), 32'(ew1[15:0]));
                    $display("ovf  write %04h @ %0d", mem1, loc1);
                end
            end
            if (done1) begin
                if (exp_done1.size() == 0) begin
                    check_eq("done1_unexpected", 32'(done1), 32'd0);
                end else begin
                    ed1 = exp_done1.pop_front();
                    check_eq("done1_err", 32'(ferr1), 32'(ed1[11]));
                    check_eq("done1_bytes", 32'(bytes1), 32'(ed1[10:0]));
                    $display("ovf  frame_done err=%0d bytes=%0d", ferr1, bytes1);
                end
            end
        end
    end

    // Reference model: payload nibbles in fq -> expected writes and frame status per instance.
    task automatic push_expect(input bit rxer, input bit fcs_good);
        int n;
        n = fq.size();
        for (int d = 0; d < 2; d++) begin
            int          end_a;
            bit          ovf;
            bit          err;
            int          a;
            int          nb;
            logic [15:0] w;
            end_a = (d == 0) ? 32767 : 60;
            ovf   = 1'b0;
            for (int wi = 0; wi < (n + 3) / 4; wi++) begin
                w = 16'h0000;
                for (int k = 0; k < 4; k++) begin
                    if (4 * wi + k < n) w[15 - 4 * k -: 4] = fq[4 * wi + k];
                end
                a = 58 + wi;
                if (a <= end_a) begin
                    if (d == 0) exp_wr0.push_back({a[14:0], w});
                    else        exp_wr1.push_back({a[14:0], w});
                end else begin
                    ovf = 1'b1;
                end
            end
            nb  = (n / 2 > 2047) ? 2047 : n / 2;
            err = rxer | ovf;
`ifdef RX_FCS_CHECK_EN
            err = err | !fcs_good;
`endif
            if (d == 0) exp_done0.push_back({err, nb[10:0]});
            else        exp_done1.push_back({err, nb[10:0]});
        end
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
    endtask

    task automatic send_frame(input int n_pre, input int err_at, input bit fcs_good);
        int lat;
        push_expect((err_at >= 0) && (err_at < fq.size()), fcs_good);
        repeat (n_pre) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        foreach (fq[i]) begin
            drive(1'b1, fq[i], (i == err_at));
            if (i == 0) check_eq("busy_in_frame", 32'(busy0), 32'd1);
        end
        drive(1'b0, 4'h0, 1'b0);
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (done0) lat = c;
        end
        check_eq("done_latency", 32'(lat), 32'd2);
        check_eq("loc_reload", 32'(loc0), 32'd58);
        check_eq("busy_after", 32'(busy0), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_ignored(input int n_pre);
        repeat (n_pre) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        drive(1'b1, 4'h1, 1'b0);
        check_eq("busy_ignored", 32'(busy0), 32'd0);
        drive(1'b0, 4'h0, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("busy_ignored_end", 32'(busy0), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_enable = 1'b1; rxd = 4'h0; rx_dv = 1'b0; rx_er = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_write", 32'(write0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_loc", 32'(loc0), 32'd58);
        check_eq("rst_mem", 32'(mem0), 32'd0);
        check_eq("rst_bytes", 32'(bytes0), 32'd0);
        check_eq("rst_ferr", 32'(ferr0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        send_frame(7, -1, 1'b0);

        send_ignored(4);

        fq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        send_frame(7, -1, 1'b0);

        fq.delete();
        for (int i = 0; i < 16; i++) fq.push_back(4'($urandom_range(0, 15)));
        send_frame(8, 7, 1'b0);

        fq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(4'($urandom_range(0, 15)));
        send_frame(6, -1, 1'b0);

        fq.delete();
        send_frame(7, -1, 1'b0);

        fq = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5};
        send_frame(15, -1, 1'b0);

        rx_enable = 1'b0;
        send_ignored(7);
        rx_enable = 1'b1;

        fq.delete();
        for (int i = 0; i < 4200; i++) fq.push_back(4'($urandom_range(0, 15)));
        send_frame(7, -1, 1'b0);

`ifdef RX_FCS_CHECK_EN
        begin
            logic [7:0]  bq[$];
            logic [31:0] c;
            for (int i = 0; i < 56; i++) bq.push_back(8'($urandom_range(0, 255)));
            c = 32'hFFFF_FFFF;
            foreach (bq[i]) begin
                c = c ^ {24'h0, bq[i]};
                for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
            c = ~c;
            bq.push_back(c[7:0]); bq.push_back(c[15:8]);
            bq.push_back(c[23:16]); bq.push_back(c[31:24]);
            fq.delete();
            foreach (bq[i]) begin
                fq.push_back(bq[i][3:0]);
                fq.push_back(bq[i][7:4]);
            end
            send_frame(7, -1, 1'b1);
            fq[5] = fq[5] ^ 4'h1;
            send_frame(7, -1, 1'b0);
        end
`endif

        // Reset in the middle of a frame: outputs clear at once and no frame_done follows.
        repeat (7) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        drive(1'b1, 4'h3, 1'b0);
        drive(1'b1, 4'hC, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy0), 32'd0);
        check_eq("midrst_mem", 32'(mem0), 32'd0);
        check_eq("midrst_loc", 32'(loc0), 32'd58);
        rx_dv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("midrst_no_busy", 32'(busy0), 32'd0);

        check_eq("wr0_left", 32'(exp_wr0.size()), 32'd0);
        check_eq("wr1_left", 32'(exp_wr1.size()), 32'd0);
        check_eq("done0_left", 32'(exp_done0.size()), 32'd0);
        check_eq("done1_left", 32'(exp_done1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
